simple_fifo_arbiter: RTL and testbench

SIMPLE_FIFO_ARBITER -- requirements
Module: simple_fifo_arbiter

---
 rtl/simple_fifo_arb_pkg.sv | 21 ++
 rtl/fifo_arb_rr_pick.sv | 36 +++
 rtl/simple_fifo_arbiter.sv | 156 +++++++++++++++
 tb/tb_simple_fifo_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/simple_fifo_arb_pkg.sv
// Shared types and widths for the simple FIFO write-port arbiter.
package simple_fifo_arb_pkg;

   // Arbiter FSM: IDLE picks an owner, GRANT forwards the owner's beats.
   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   // Per-packet beat counter width; MAX_BEATS must fit, so it never wraps.
   localparam int BEAT_CNT_W = 16;

   // Width of each optional accepted-beat statistics counter.
   localparam int STAT_CNT_W = 32;

   // Saturating increment for the statistics counters.
   function automatic logic [STAT_CNT_W-1:0] stat_sat_inc(input logic [STAT_CNT_W-1:0] v);
      return (&v) ? v : v + STAT_CNT_W'(1);
   endfunction

endpackage

// File: rtl/fifo_arb_rr_pick.sv
// Combinational round-robin picker: scans requests starting at rr_ptr_i
// and returns a one-hot winner plus an any-request flag.
module fifo_arb_rr_pick #(
   parameter int NUM_REQ = 2,
   parameter int PTR_W   = 1
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [PTR_W-1:0]   rr_ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic               any_o
);

   // One spare bit so rr_ptr + offset can exceed NUM_REQ-1 before folding.
   localparam int SW = PTR_W + 1;

   logic          found;
   logic [SW-1:0] sum;

   assign any_o = |req_i;

   // First requester at or after rr_ptr_i (wrapping) wins.
   always_comb begin
      gnt_o = '0;
      found = 1'b0;
      sum   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         sum = {1'b0, rr_ptr_i} + SW'(k);
         if (sum >= SW'(NUM_REQ)) sum = sum - SW'(NUM_REQ);
         if (!found && req_i[sum[PTR_W-1:0]]) begin
            gnt_o[sum[PTR_W-1:0]] = 1'b1;
            found                 = 1'b1;
         end
      end
   end

endmodule

// File: rtl/simple_fifo_arbiter.sv
// Packet arbiter sharing one simple-FIFO write port among NUM_REQ requesters.
// An owner is picked round-robin in IDLE and holds the port until its last
// beat, or until MAX_BEATS beats have gone through (force-release with a
// trunc_pulse one cycle later).
// Optional: define SIMPLE_FIFO_ARB_STATS_EN to add per-requester saturating
// accepted-beat counters (stat_beats) with a synchronous stat_clear.
module simple_fifo_arbiter
   import simple_fifo_arb_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REQ    = 2,
   parameter int MAX_BEATS  = 256
) (
   input  logic                          ACLK,
   input  logic                          ARESETN,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]            req_last,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          fifo_full,
   output logic                          fifo_wr_en,
   output logic [DATA_WIDTH-1:0]         fifo_wr_data,
   output logic [NUM_REQ-1:0]            grant,
   output logic                          trunc_pulse
`ifdef SIMPLE_FIFO_ARB_STATS_EN
   ,
   input  logic                          stat_clear,
   output logic [NUM_REQ*STAT_CNT_W-1:0] stat_beats
`endif
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [BEAT_CNT_W:0] MAX_CNT = (BEAT_CNT_W + 1)'(MAX_BEATS);

   arb_state_e            state_q, state_d;
   logic [NUM_REQ-1:0]    grant_q, grant_d;
   logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic [BEAT_CNT_W-1:0] beat_cnt_q, beat_cnt_d;
   logic                  trunc_q, trunc_d;

   logic [NUM_REQ-1:0]    pick_gnt;
   logic                  pick_any;
   logic [DATA_WIDTH-1:0] owner_data;
   logic                  owner_last;
   logic [PTR_W-1:0]      owner_idx;
   logic [PTR_W-1:0]      next_ptr;
   logic [BEAT_CNT_W:0]   beat_inc;
   logic                  accept;
   logic                  at_max;

   fifo_arb_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_pick (
      .req_i    (req_valid),
      .rr_ptr_i (rr_ptr_q),
      .gnt_o    (pick_gnt),
      .any_o    (pick_any)
   );

   // Owner mux driven only by the registered grant; non-owners never leak in.
   always_comb begin
      owner_data = '0;
      owner_last = 1'b0;
      owner_idx  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_q[i]) begin
            owner_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            owner_last = req_last[i];
            owner_idx  = PTR_W'(i);
         end
      end
   end

   assign req_ready    = (state_q == GRANT && !fifo_full) ? grant_q : '0;
   assign accept       = |(req_valid & req_ready);
   assign fifo_wr_en   = accept;
   assign fifo_wr_data = owner_data;
   assign grant        = grant_q;
   assign trunc_pulse  = trunc_q;

   assign beat_inc = {1'b0, beat_cnt_q} + (BEAT_CNT_W + 1)'(1);
   assign at_max   = (beat_inc == MAX_CNT);
   assign next_ptr = (owner_idx == PTR_W'(NUM_REQ - 1)) ? '0 : owner_idx + PTR_W'(1);

   // Next-state: arbitrate in IDLE, count accepted beats and release in GRANT.
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      rr_ptr_d   = rr_ptr_q;
      beat_cnt_d = beat_cnt_q;
      trunc_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               state_d    = GRANT;
               grant_d    = pick_gnt;
               beat_cnt_d = '0;
            end
         end
         GRANT: begin
            if (accept) begin
               beat_cnt_d = beat_inc[BEAT_CNT_W-1:0];
               if (owner_last || at_max) begin
                  state_d  = IDLE;
                  grant_d  = '0;
                  rr_ptr_d = next_ptr;
                  // A real last on the limit beat is a normal end, not a truncation.
                  trunc_d  = at_max && !owner_last;
               end
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   // State registers; reset aborts any packet in flight.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         rr_ptr_q   <= '0;
         beat_cnt_q <= '0;
         trunc_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         rr_ptr_q   <= rr_ptr_d;
         beat_cnt_q <= beat_cnt_d;
         trunc_q    <= trunc_d;
      end
   end

`ifdef SIMPLE_FIFO_ARB_STATS_EN
   logic [NUM_REQ-1:0][STAT_CNT_W-1:0] stat_q;

   assign stat_beats = stat_q;

   // Per-requester accepted-beat counters; clear wins over a same-cycle beat.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         stat_q <= '0;
      end else if (stat_clear) begin
         stat_q <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && req_ready[i]) stat_q[i] <= stat_sat_inc(stat_q[i]);
         end
      end
   end
`endif

endmodule

// File: tb/tb_simple_fifo_arbiter.sv
// Directed bench for simple_fifo_arbiter (2 requesters, MAX_BEATS = 4).
// Inputs change 1 time unit after the rising edge; outputs are sampled
// 2 units later, well clear of either clock edge.
module tb_simple_fifo_arbiter;

   logic        ACLK;
   logic        ARESETN;
   logic [1:0]  req_valid;
   logic [63:0] req_data;
   logic [1:0]  req_last;
   logic [1:0]  req_ready;
   logic        fifo_full;
   logic        fifo_wr_en;
   logic [31:0] fifo_wr_data;
   logic [1:0]  grant;
   logic        trunc_pulse;
`ifdef SIMPLE_FIFO_ARB_STATS_EN
   logic        stat_clear;
   logic [63:0] stat_beats;
`endif

   int checks;
   int failures;

   simple_fifo_arbiter #(
      .DATA_WIDTH (32),
      .NUM_REQ    (2),
      .MAX_BEATS  (4)
   ) dut (
      .ACLK         (ACLK),
      .ARESETN      (ARESETN),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_last     (req_last),
      .req_ready    (req_ready),
      .fifo_full    (fifo_full),
      .fifo_wr_en   (fifo_wr_en),
      .fifo_wr_data (fifo_wr_data),
      .grant        (grant),
      .trunc_pulse  (trunc_pulse)
`ifdef SIMPLE_FIFO_ARB_STATS_EN
      ,
      .stat_clear   (stat_clear),
      .stat_beats   (stat_beats)
`endif
   );

   initial begin
      ACLK = 1'b0;
      forever #5 ACLK = ~ACLK;
   end

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic set_data(input int r, input logic [31:0] d);
      if (r == 0) req_data[31:0] = d;
      else        req_data[63:32] = d;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [1:0] g, input logic [1:0] r,
                          input logic we, input logic [31:0] wd, input logic tp);
      chk({tag, ".grant"},      64'(grant),        64'(g));
      chk({tag, ".req_ready"},  64'(req_ready),    64'(r));
      chk({tag, ".fifo_wr_en"}, 64'(fifo_wr_en),   64'(we));
      chk({tag, ".wr_data"},    64'(fifo_wr_data), 64'(wd));
      chk({tag, ".trunc"},      64'(trunc_pulse),  64'(tp));
   endtask

`ifdef SIMPLE_FIFO_ARB_STATS_EN
   task automatic send_pkt(input int r, input int n);
      req_valid = (r == 0) ? 2'b01 : 2'b10;
      req_last  = 2'b00;
      tick();
      for (int k = 0; k < n; k++) begin
         req_last = (k == n - 1) ? req_valid : 2'b00;
         tick();
      end
      req_valid = 2'b00;
      req_last  = 2'b00;
      tick();
   endtask
`endif

   initial begin
      logic [1:0] oh;
      checks    = 0;
      failures  = 0;
      ARESETN   = 1'b0;
      req_valid = 2'b01;
      req_last  = 2'b00;
      req_data  = '0;
      fifo_full = 1'b0;
      set_data(0, 32'h55);
`ifdef SIMPLE_FIFO_ARB_STATS_EN
      stat_clear = 1'b0;
`endif

      // Reset held with a request pending: everything stays quiet.
      tick(); tick(); settle();
      chk_out("reset", 2'b00, 2'b00, 1'b0, 32'h0, 1'b0);
      req_valid = 2'b00;
      ARESETN   = 1'b1;
      tick();

      // 3-beat packet from req0, grant one cycle after valid.
      req_valid = 2'b01; set_data(0, 32'hA1); settle();
      chk_out("t1_arb", 2'b00, 2'b00, 1'b0, 32'h0, 1'b0);
      tick(); settle();
      chk_out("t1_b1", 2'b01, 2'b01, 1'b1, 32'hA1, 1'b0);
      tick(); set_data(0, 32'hA2); settle();
      chk_out("t1_b2", 2'b01, 2'b01, 1'b1, 32'hA2, 1'b0);
      tick(); set_data(0, 32'hA3); req_last = 2'b01; settle();
      chk_out("t1_b3", 2'b01, 2'b01, 1'b1, 32'hA3, 1'b0);
      tick(); req_valid = 2'b00; req_last = 2'b00; settle();
      chk_out("t1_idle", 2'b00, 2'b00, 1'b0, 32'h0, 1'b0);

      // Reset pulse brings rr_ptr back to 0 before the fairness test.
      ARESETN = 1'b0; settle(); ARESETN = 1'b1;
      tick();

      // Both requesters stream 2-beat packets: owners go 0,1,0,1.
      for (int p = 0; p < 4; p++) begin
         oh = (p % 2 == 0) ? 2'b01 : 2'b10;
         req_valid = 2'b11; req_last = 2'b00;
         set_data(0, 32'hDEAD); set_data(1, 32'hDEAD); settle();
         chk_out("t2_idle", 2'b00, 2'b00, 1'b0, 32'h0, 1'b0);
         tick();
         set_data(p % 2, 32'h100 + 32'(p * 2));
         req_last = ~oh;                  // non-owner last must be ignored
         settle();
         chk_out("t2_b0", oh, oh, 1'b1, 32'h100 + 32'(p * 2), 1'b0);
         tick();
         set_data(p % 2, 32'h101 + 32'(p * 2));
         req_last = 2'b11;
         settle();
         chk_out("t2_b1", oh, oh, 1'b1, 32'h101 + 32'(p * 2), 1'b0);
         tick();
      end
      req_valid = 2'b00; req_last = 2'b00;

      // fifo_full stalls beat 2 for 4 cycles and the last beat for 1.
      req_valid = 2'b01; set_data(0, 32'hC1); settle();
      chk_out("t3_arb", 2'b00, 2'b00, 1'b0, 32'h0, 1'b0);
      tick(); settle();
      chk_out("t3_b1", 2'b01, 2'b01, 1'b1, 32'hC1, 1'b0);
      tick(); set_data(0, 32'hC2); fifo_full = 1'b1;
      for (int k = 0; k < 4; k++) begin
         settle();
         chk_out("t3_full", 2'b01, 2'b00, 1'b0, 32'hC2, 1'b0);
         tick();
      end
      fifo_full = 1'b0; settle();
      chk_out("t3_b2", 2'b01, 2'b01, 1'b1, 32'hC2, 1'b0);
      tick(); set_data(0, 32'hC3); req_last = 2'b01; fifo_full = 1'b1; settle();
      chk_out("t3_lastfull", 2'b01, 2'b00, 1'b0, 32'hC3, 1'b0);
      tick(); fifo_full = 1'b0; settle();
      chk_out("t3_b3", 2'b01, 2'b01, 1'b1, 32'hC3, 1'b0);
      tick(); req_valid = 2'b00; req_last = 2'b00; settle();
      chk_out("t3_idle", 2'b00, 2'b00, 1'b0, 32'h0, 1'b0);

      // req1 streams without last: force-release after 4 beats.
      req_valid = 2'b10; set_data(1, 32'hD0); settle();
      chk_out("t4_arb", 2'b00, 2'b00, 1'b0, 32'h0, 1'b0);
      tick();
      for (int k = 0; k < 4; k++) begin
         set_data(1, 32'hD0 + 32'(k)); settle();
         chk_out("t4_beat", 2'b10, 2'b10, 1'b1, 32'hD0 + 32'(k), 1'b0);
         tick();
      end
      set_data(1, 32'hD4); settle();
      chk_out("t4_trunc", 2'b00, 2'b00, 1'b0, 32'h0, 1'b1);
      tick(); settle();
      chk_out("t4_rearb", 2'b10, 2'b10, 1'b1, 32'hD4, 1'b0);
      tick(); set_data(1, 32'hD5); settle();
      chk_out("t4_d5", 2'b10, 2'b10, 1'b1, 32'hD5, 1'b0);
      // Owner drops valid mid-packet: grant held, nothing written.
      tick(); req_valid = 2'b00;
      for (int k = 0; k < 3; k++) begin
         settle();
         chk_out("t4_hold", 2'b10, 2'b10, 1'b0, 32'hD5, 1'b0);
         tick();
      end
      req_valid = 2'b10; req_last = 2'b10; set_data(1, 32'hD6); settle();
      chk_out("t4_d6", 2'b10, 2'b10, 1'b1, 32'hD6, 1'b0);
      tick(); req_valid = 2'b00; req_last = 2'b00; settle();
      chk_out("t4_idle", 2'b00, 2'b00, 1'b0, 32'h0, 1'b0);

      // Last coincides with the 4th beat: normal release, no trunc_pulse.
      req_valid = 2'b01; tick();
      for (int k = 0; k < 4; k++) begin
         set_data(0, 32'hE0 + 32'(k));
         req_last = (k == 3) ? 2'b01 : 2'b00;
         settle();
         chk_out("t5_beat", 2'b01, 2'b01, 1'b1, 32'hE0 + 32'(k), 1'b0);
         tick();
      end
      req_valid = 2'b00; req_last = 2'b00; settle();
      chk_out("t5_notrunc", 2'b00, 2'b00, 1'b0, 32'h0, 1'b0);
      tick(); settle();
      chk_out("t5_notrunc2", 2'b00, 2'b00, 1'b0, 32'h0, 1'b0);
      tick();

      // Reset on beat 2 of a req1 packet; next grant goes to req0.
      req_valid = 2'b10; set_data(1, 32'hF0); tick(); settle();
      chk_out("t6_b1", 2'b10, 2'b10, 1'b1, 32'hF0, 1'b0);
      tick(); set_data(1, 32'hF1); settle();
      chk_out("t6_b2", 2'b10, 2'b10, 1'b1, 32'hF1, 1'b0);
      ARESETN = 1'b0; #1;
      chk_out("t6_rst", 2'b00, 2'b00, 1'b0, 32'h0, 1'b0);
      req_valid = 2'b11; req_last = 2'b01; set_data(0, 32'h600);
      #1 ARESETN = 1'b1;
      tick(); settle();
      chk_out("t6_regrant", 2'b01, 2'b01, 1'b1, 32'h600, 1'b0);
      tick(); req_valid = 2'b00; req_last = 2'b00; settle();
      chk_out("t6_idle", 2'b00, 2'b00, 1'b0, 32'h0, 1'b0);
      tick();

`ifdef SIMPLE_FIFO_ARB_STATS_EN
      // 10 beats from req0, 7 from req1, then a synchronous clear.
      stat_clear = 1'b1; tick(); stat_clear = 1'b0;
      send_pkt(0, 3); send_pkt(0, 3); send_pkt(0, 4);
      send_pkt(1, 3); send_pkt(1, 4);
      settle();
      chk("stat_beats", stat_beats, 64'h00000007_0000000A);
      stat_clear = 1'b1; tick(); stat_clear = 1'b0; settle();
      chk("stat_clear", stat_beats, 64'h0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
